// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage in-order core (no forwarding).
// Tracks in-flight register writes with per-register countdowns, holds
// dependent instructions in ID, and sequences branch resolution and halt drain.
module pipe_stall_ctrl #(
  parameter int NUM_REGS   = 8,
  parameter int REG_ID_W   = 3,
  parameter int PIPE_DEPTH = 3,
  parameter int BR_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                id_rs_valid,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic                id_rt_valid,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_wr_en,
  input  logic [REG_ID_W-1:0] id_wr_reg,
  input  logic                id_is_branch,
  input  logic                id_is_halt,
  input  logic                ex_br_resolved,
  input  logic                ex_br_taken,
  output logic                id_issue,
  output logic                stall_if,
  output logic                bubble_idex,
  output logic                flush_ifid,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                halted,
  output logic                err
);

  localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
  localparam int BR_W  = $clog2(BR_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, BR_WAIT, DRAIN, HALT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [BR_W-1:0]   br_cnt;
  logic              hz;

  // A register is busy while its write is still in flight.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_mask[i] = (cnt[i] != '0);
    end
  end

  // Read-after-write hazard on either source; the destination is never checked.
  always_comb begin
    hz = id_valid & ((id_rs_valid & busy_mask[id_rs]) |
                     (id_rt_valid & busy_mask[id_rt]));
  end

  // Pipeline control decoded from state, scoreboard and the current ID/EX inputs.
  always_comb begin
    id_issue    = 1'b0;
    stall_if    = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    unique case (state)
      RUN: begin
        if (hz) begin
          stall_if    = 1'b1;
          bubble_idex = 1'b1;
        end else begin
          id_issue = id_valid;
        end
      end
      BR_WAIT: begin
        // On resolve the PC is released; a taken branch also kills the
        // wrong-path fetch sitting in IF-ID.
        bubble_idex = 1'b1;
        stall_if    = ~ex_br_resolved;
        flush_ifid  = ex_br_resolved & ex_br_taken;
      end
      DRAIN, HALT: begin
        stall_if    = 1'b1;
        bubble_idex = 1'b1;
      end
      default: begin
        stall_if    = 1'b0;
      end
    endcase
  end

  assign halted = (state == HALT);

  // Scoreboard countdowns; a new write reload wins over the decrement.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (id_issue && id_wr_en && (id_wr_reg == REG_ID_W'(i))) begin
        cnt[i] <= CNT_W'(PIPE_DEPTH);
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Control FSM with branch-wait timer and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      br_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (ex_br_resolved && (state != BR_WAIT)) begin
        err <= 1'b1;
      end
      unique case (state)
        RUN: begin
          if (id_issue && id_is_branch) begin
            state  <= BR_WAIT;
            br_cnt <= '0;
          end else if (id_issue && id_is_halt) begin
            state <= DRAIN;
          end
        end
        BR_WAIT: begin
          br_cnt <= br_cnt + BR_W'(1);
          if (ex_br_resolved) begin
            state <= RUN;
          end else if (br_cnt == BR_W'(BR_TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= RUN;
          end
        end
        DRAIN: begin
          if (busy_mask == '0) begin
            state <= HALT;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expectations are queued per cycle and
// checked against the combinational outputs on the falling edge.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_valid, id_rt_valid, id_wr_en;
  logic [2:0] id_rs, id_rt, id_wr_reg;
  logic       id_is_branch, id_is_halt, ex_br_resolved, ex_br_taken;
  logic       id_issue, stall_if, bubble_idex, flush_ifid, halted, err;
  logic [7:0] busy_mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       issue;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [7:0] busy;
    logic       hlt;
    logic       er;
  } exp_t;

  exp_t sb[$];

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_valid(id_rs_valid), .id_rs(id_rs),
    .id_rt_valid(id_rt_valid), .id_rt(id_rt),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_branch(id_is_branch), .id_is_halt(id_is_halt),
    .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .id_issue(id_issue), .stall_if(stall_if), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .busy_mask(busy_mask), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs_valid = 0; id_rs = 0; id_rt_valid = 0; id_rt = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_branch = 0; id_is_halt = 0;
    ex_br_resolved = 0; ex_br_taken = 0;
  endtask

  task automatic id_in(input logic v, input logic rsv, input logic [2:0] rs,
                       input logic rtv, input logic [2:0] rt,
                       input logic we, input logic [2:0] wr,
                       input logic br, input logic hl);
    id_valid = v; id_rs_valid = rsv; id_rs = rs; id_rt_valid = rtv; id_rt = rt;
    id_wr_en = we; id_wr_reg = wr; id_is_branch = br; id_is_halt = hl;
  endtask

  task automatic expect_out(input string tag, input logic i, input logic s,
                            input logic b, input logic f, input logic [7:0] bm,
                            input logic h, input logic e);
    exp_t x;
    x.tag = tag; x.issue = i; x.stall = s; x.bubble = b; x.flush = f;
    x.busy = bm; x.hlt = h; x.er = e;
    sb.push_back(x);
  endtask

  // Check queued expectations mid-cycle, then advance to just after the next edge.
  task automatic tick();
    exp_t x;
    @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, ".id_issue"},    8'(id_issue),    8'(x.issue));
      chk({x.tag, ".stall_if"},    8'(stall_if),    8'(x.stall));
      chk({x.tag, ".bubble_idex"}, 8'(bubble_idex), 8'(x.bubble));
      chk({x.tag, ".flush_ifid"},  8'(flush_ifid),  8'(x.flush));
      chk({x.tag, ".busy_mask"},   busy_mask,       x.busy);
      chk({x.tag, ".halted"},      8'(halted),      8'(x.hlt));
      chk({x.tag, ".err"},         8'(err),         8'(x.er));
      chk({x.tag, ".issue_and_stall"}, 8'(id_issue & stall_if), 8'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    expect_out("rst_state", 0,0,0,0,8'h00,0,0); tick();

    // back-to-back RAW on r3
    idle(); id_in(1,0,0,0,0,1,3,0,0); expect_out("raw_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,1,3,0,0,0,0,0,0); expect_out("raw_c1", 0,1,1,0,8'h08,0,0); tick();
    expect_out("raw_c2", 0,1,1,0,8'h08,0,0); tick();
    expect_out("raw_c3", 0,1,1,0,8'h08,0,0); tick();
    expect_out("raw_c4", 1,0,0,0,8'h00,0,0); tick();
    idle(); expect_out("raw_c5", 0,0,0,0,8'h00,0,0); tick();

    // destination match is not a hazard; reload of r2
    idle(); id_in(1,0,0,0,0,1,2,0,0); expect_out("nfh_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,1,4,1,5,1,2,0,0); expect_out("nfh_c1", 1,0,0,0,8'h04,0,0); tick();
    idle(); expect_out("nfh_c2", 0,0,0,0,8'h04,0,0); tick();
    expect_out("nfh_c3", 0,0,0,0,8'h04,0,0); tick();
    expect_out("nfh_c4", 0,0,0,0,8'h04,0,0); tick();
    expect_out("nfh_c5", 0,0,0,0,8'h00,0,0); tick();

    // taken branch
    idle(); id_in(1,0,0,0,0,0,0,1,0); expect_out("tk_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); expect_out("tk_c1", 0,1,1,0,8'h00,0,0); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 1;
    expect_out("tk_c2", 0,0,1,1,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("tk_c3", 1,0,0,0,8'h00,0,0); tick();

    // not-taken branch
    idle(); id_in(1,0,0,0,0,0,0,1,0); expect_out("nt_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 0;
    expect_out("nt_c1", 0,0,1,0,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("nt_c2", 1,0,0,0,8'h00,0,0); tick();

    // branch and halt together: branch wins
    idle(); id_in(1,0,0,0,0,0,0,1,1); expect_out("bh_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 1;
    expect_out("bh_c1", 0,0,1,1,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("bh_c2", 1,0,0,0,8'h00,0,0); tick();

    // branch timeout
    idle(); id_in(1,0,0,0,0,0,0,1,0); expect_out("to_c0", 1,0,0,0,8'h00,0,0); tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      expect_out($sformatf("to_w%0d", k), 0,1,1,0,8'h00,0,0); tick();
    end
    expect_out("to_c5", 0,0,0,0,8'h00,0,1); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("to_c6", 1,0,0,0,8'h00,0,1); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 1;
    expect_out("to_c7", 0,0,0,0,8'h00,0,1); tick();
    idle(); expect_out("to_c8", 0,0,0,0,8'h00,0,1); tick();

    // reset clears err; spurious resolve in RUN
    do_reset(); expect_out("rst2", 0,0,0,0,8'h00,0,0); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 1;
    expect_out("sp_c0", 0,0,0,0,8'h00,0,0); tick();
    idle(); expect_out("sp_c1", 0,0,0,0,8'h00,0,1); tick();

    // halt drain
    do_reset(); expect_out("rst3", 0,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,1,5,0,0); expect_out("hd_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,1); expect_out("hd_c1", 1,0,0,0,8'h20,0,0); tick();
    idle(); expect_out("hd_c2", 0,1,1,0,8'h20,0,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("hd_c3", 0,1,1,0,8'h20,0,0); tick();
    idle(); expect_out("hd_c4", 0,1,1,0,8'h00,0,0); tick();
    expect_out("hd_c5", 0,1,1,0,8'h00,1,0); tick();
    idle(); id_in(1,0,0,0,0,0,0,0,0); expect_out("hd_c6", 0,1,1,0,8'h00,1,0); tick();
    idle(); ex_br_resolved = 1; ex_br_taken = 0;
    expect_out("hd_c7", 0,1,1,0,8'h00,1,0); tick();
    idle(); expect_out("hd_c8", 0,1,1,0,8'h00,1,1); tick();

    // reset in the middle of a RAW stall
    do_reset(); expect_out("rst4", 0,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,0,0,0,0,1,3,0,0); expect_out("ms_c0", 1,0,0,0,8'h00,0,0); tick();
    idle(); id_in(1,1,3,0,0,0,0,0,0); expect_out("ms_c1", 0,1,1,0,8'h08,0,0); tick();
    rst = 1; tick();
    rst = 0;
    expect_out("ms_c3", 1,0,0,0,8'h00,0,0); tick();
    idle(); expect_out("ms_c4", 0,0,0,0,8'h00,0,0); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
